// File: rtl/rdyacpt_fifo.sv
// rdyacpt_fifo
// Elastic DEPTH-entry circular buffer for the rdy/acpt streaming handshake.
//
// Handshake semantics (both sides):
//   A word moves across an interface on a rising clk edge when the sender's
//   rdy and the receiver's acpt are both high. The sender holds rdy and data
//   stable until that edge. The receiver may raise or lower acpt freely.
//   upstream_acpt and downstream_rdy come from registered state only, so
//   there is no combinational path from either input handshake to the
//   opposite output. This lets long chains of these buffers close timing.
//
// A flush at an edge empties the buffer and cancels any push or pop in that
// same cycle. Storage is not reset. downstream_data is meaningless while
// downstream_rdy is low.

module rdyacpt_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             upstream_rdy,
  input  logic [WIDTH-1:0] upstream_data,
  output logic             upstream_acpt,
  output logic             downstream_rdy,
  output logic [WIDTH-1:0] downstream_data,
  input  logic             downstream_acpt,
  output logic [LW-1:0]    level,
  output logic             almost_full
);

  // Pointer width. DEPTH is at least 2, so $clog2 is at least 1.
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL    = LW'(AF_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;

  logic             push;
  logic             pop;
  logic [PW-1:0]    wr_ptr_inc;
  logic [PW-1:0]    rd_ptr_inc;
  logic [LW-1:0]    level_nxt;

  // The handshake outputs come from the registered level only. When the
  // buffer is full, a same-cycle pop does not reopen upstream_acpt. The
  // freed slot is offered from the next cycle.
  assign upstream_acpt   = (level_q != FULL_LVL);
  assign downstream_rdy  = (level_q != '0);
  assign downstream_data = mem[rd_ptr];
  assign level           = level_q;
  assign almost_full     = (level_q >= AF_LVL);

  // Qualified transfers. An input rdy or acpt is ignored when the
  // matching output is low.
  assign push = upstream_rdy & upstream_acpt;
  assign pop  = downstream_rdy & downstream_acpt;

  // Wrapping pointer increments. DEPTH need not be a power of two, so the
  // wrap point is compared explicitly.
  always_comb begin
    wr_ptr_inc = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
    rd_ptr_inc = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
  end

  // Next occupancy. A simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_nxt = level_q;
    unique case ({push, pop})
      2'b10:   level_nxt = level_q + LW'(1);
      2'b01:   level_nxt = level_q - LW'(1);
      default: level_nxt = level_q;
    endcase
  end

  // Pointers and level. Reset and flush both return the buffer to empty.
  // A flush takes priority over any transfer in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr_inc;
      if (pop)  rd_ptr <= rd_ptr_inc;
      level_q <= level_nxt;
    end
  end

  // Payload storage. It has no reset. A write cancelled by flush or reset
  // is harmless because the pointers no longer reach it as valid data.
  always_ff @(posedge clk) begin
    if (push && !flush && reset_n) begin
      mem[wr_ptr] <= upstream_data;
    end
  end

endmodule

// File: tb/tb_rdyacpt_fifo.sv
// tb_rdyacpt_fifo
// Directed checks on a DEPTH=4 instance, followed by a randomised
// scoreboard run on a DEPTH=5 instance.

module tb_rdyacpt_fifo;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: DEPTH=4, AF_THRESH=3 ----------------
  logic         flush, u_rdy, u_acpt, d_rdy, d_acpt, af;
  logic [W-1:0] u_data, d_data;
  logic [2:0]   lvl;

  rdyacpt_fifo #(.WIDTH(W), .DEPTH(4), .AF_THRESH(3)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .upstream_rdy(u_rdy), .upstream_data(u_data), .upstream_acpt(u_acpt),
    .downstream_rdy(d_rdy), .downstream_data(d_data),
    .downstream_acpt(d_acpt), .level(lvl), .almost_full(af)
  );

  // ---------------- DUT B: DEPTH=5, AF_THRESH=4 ----------------
  logic         r_flush, r_u_rdy, r_u_acpt, r_d_rdy, r_d_acpt, r_af;
  logic [W-1:0] r_u_data, r_d_data;
  logic [2:0]   r_lvl;

  rdyacpt_fifo #(.WIDTH(W), .DEPTH(5), .AF_THRESH(4)) dut_r (
    .clk(clk), .reset_n(reset_n), .flush(r_flush),
    .upstream_rdy(r_u_rdy), .upstream_data(r_u_data), .upstream_acpt(r_u_acpt),
    .downstream_rdy(r_d_rdy), .downstream_data(r_d_data),
    .downstream_acpt(r_d_acpt), .level(r_lvl), .almost_full(r_af)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge, settling 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [W-1:0] data,
                       input logic acpt, input logic fl);
    u_rdy  = rdy;
    u_data = data;
    d_acpt = acpt;
    flush  = fl;
  endtask

  task automatic check_a(input string tag, input int e_lvl, input logic e_drdy,
                         input logic e_uacpt, input logic e_af);
    check({tag, "_level"}, 32'(lvl), 32'(e_lvl));
    check({tag, "_drdy"}, 32'(d_rdy), 32'(e_drdy));
    check({tag, "_uacpt"}, 32'(u_acpt), 32'(e_uacpt));
    check({tag, "_af"}, 32'(af), 32'(e_af));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    r_flush = 1'b0; r_u_rdy = 1'b0; r_u_data = '0; r_d_acpt = 1'b0;

    // T1: reset held with the clock running, then released
    repeat (3) step();
    check_a("t1_in_reset", 0, 1'b0, 1'b1, 1'b0);
    check("t1_r_level", 32'(r_lvl), 32'd0);
    reset_n = 1'b1;
    repeat (2) step();
    check_a("t1_after_rel", 0, 1'b0, 1'b1, 1'b0);

    // T2: streaming 0x01..0x10 with the consumer always accepting
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      step();
      check("t2_data", 32'(d_data), 32'(i));
      check("t2_level", 32'(lvl), 32'd1);
      check("t2_drdy", 32'(d_rdy), 32'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check_a("t2_drained", 0, 1'b0, 1'b1, 1'b0);

    // T3: fill with a stalled consumer, then release one word
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
      step();
      check_a("t3_fill", i + 1, 1'b1, (i != 3), (i >= 2));
      check("t3_head", 32'(d_data), 32'hA0);
    end
    // Producer keeps offering while full. It must not be taken.
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    step();
    check_a("t3_pop1", 3, 1'b1, 1'b1, 1'b1);
    check("t3_head_a1", 32'(d_data), 32'hA1);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 2; i < 4; i++) begin
      step();
      check("t3_drain_head", 32'(d_data), 32'(8'hA0 + i));
    end
    step();
    check_a("t3_empty", 0, 1'b0, 1'b1, 1'b0);

    // T4: hold level at 2 with a simultaneous push and pop for 8 cycles
    drive(1'b1, 8'h30, 1'b0, 1'b0); step();
    drive(1'b1, 8'h31, 1'b0, 1'b0); step();
    check("t4_pre_level", 32'(lvl), 32'd2);
    check("t4_pre_head", 32'(d_data), 32'h30);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, W'(8'h32 + i), 1'b1, 1'b0);
      step();
      check("t4_level", 32'(lvl), 32'd2);
      check("t4_head", 32'(d_data), 32'(8'h31 + i));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("t4_tail_head", 32'(d_data), 32'h39);
    step();
    check_a("t4_empty", 0, 1'b0, 1'b1, 1'b0);

    // T5: flush at level 3 with a push and a pop in the same cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
      step();
    end
    check("t5_pre_level", 32'(lvl), 32'd3);
    drive(1'b1, 8'h63, 1'b1, 1'b1);
    #3;
    // During the flush cycle the handshake outputs still reflect level 3.
    check_a("t5_flush_cycle", 3, 1'b1, 1'b1, 1'b1);
    step();
    check_a("t5_flushed", 0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    step();
    check("t5_first", 32'(d_data), 32'h55);
    check("t5_level", 32'(lvl), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check_a("t5_empty", 0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);

    // T6: random 50% rdy/acpt on DEPTH=5 against a queue model
    begin
      logic m_push, m_pop;
      int   m_lvl;
      m_push = 1'b0; m_pop = 1'b0; m_lvl = 0;
      exp_q.delete();
      for (int c = 0; c < 10000; c++) begin
        step();
        if (m_pop)  void'(exp_q.pop_front());
        if (m_push) exp_q.push_back(r_u_data);
        m_lvl = exp_q.size();
        check("t6_level", 32'(r_lvl), 32'(m_lvl));
        check("t6_uacpt", 32'(r_u_acpt), 32'(m_lvl != 5));
        check("t6_drdy", 32'(r_d_rdy), 32'(m_lvl != 0));
        check("t6_af", 32'(r_af), 32'(m_lvl >= 4));
        if (m_lvl != 0) check("t6_data", 32'(r_d_data), 32'(exp_q[0]));
        r_u_rdy  = 1'($urandom_range(0, 1));
        r_u_data = W'($urandom_range(0, 255));
        r_d_acpt = 1'($urandom_range(0, 1));
        m_push = r_u_rdy && (m_lvl != 5);
        m_pop  = r_d_acpt && (m_lvl != 0);
        // The model never pushes into a full buffer or pops an empty one.
        if (r_u_rdy && r_u_acpt) check("t6_no_push_full", 32'(r_lvl == 3'd5), 32'd0);
        if (r_d_acpt && r_d_rdy) check("t6_no_pop_empty", 32'(r_lvl == 3'd0), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
